// File: rtl/yin_pkg.sv
// yin_pkg: constants and types shared by the YIN window loader and difference engine.
package yin_pkg;

    function automatic int yin_win_len(input int window_size_bits, input int max_tau);
        return (1 << window_size_bits) + max_tau;
    endfunction

    typedef enum logic [2:0] {S_FILL, S_HOP, S_START, S_WAIT_LOW, S_WAIT_DONE} loader_state_e;

endpackage

// File: rtl/sample_shift_reg.sv
// sample_shift_reg: DEPTH x WIDTH sample shift register; the newest sample enters the top slice.
// The parallel load path exists only when LOAD_EN is set.
module sample_shift_reg #(
    parameter int DEPTH   = 2,
    parameter int WIDTH   = 8,
    parameter bit LOAD_EN = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_shift,
    input  logic [WIDTH-1:0]       i_din,
    input  logic                   i_load,
    input  logic [DEPTH*WIDTH-1:0] i_load_data,
    output logic [DEPTH*WIDTH-1:0] o_data
);
    logic [DEPTH*WIDTH-1:0] r_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_data <= '0;
        else if (LOAD_EN && i_load)
            r_data <= i_load_data;
        else if (i_shift)
            r_data <= {i_din, r_data[DEPTH*WIDTH-1:WIDTH]};
    end

    assign o_data = r_data;

endmodule

// File: rtl/yin_window_loader.sv
// yin_window_loader: builds the sliding sample window for the YIN difference engine and launches it.
// Define YIN_LOADER_DBUF_EN to keep accepting samples into a shadow register while the engine runs.
module yin_window_loader
    import yin_pkg::*;
#(
    parameter int  DATA_WIDTH       = 8,
    parameter int  WINDOW_SIZE_BITS = 8,
    parameter int  MAX_TAU          = 40,
    parameter int  HOP_SIZE         = 64,
    localparam int N                = yin_win_len(WINDOW_SIZE_BITS, MAX_TAU)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [DATA_WIDTH-1:0]   sample_in,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    output logic [DATA_WIDTH*N-1:0] window_data,
    output logic                    window_start,
    input  logic                    engine_ready,
    output logic                    window_busy,
    output logic [15:0]             frame_count,
    output logic                    overrun
);
    localparam int CW = $clog2(N + 1);

    loader_state_e r_state, w_next;
    logic [CW-1:0] r_cnt, w_thr;
    logic [15:0]   r_frame_count;
    logic          r_overrun;
    logic          w_acc, w_busy, w_enter_start, w_direct;

    assign w_busy        = r_state inside {S_START, S_WAIT_LOW, S_WAIT_DONE};
    assign w_thr         = (r_state == S_FILL) ? CW'(N) : CW'(HOP_SIZE);
    assign w_acc         = sample_valid && sample_ready;
    assign w_enter_start = (w_next == S_START);

`ifdef YIN_LOADER_DBUF_EN
    logic [DATA_WIDTH*N-1:0] w_shadow;

    // Samples keep flowing into the shadow until the next hop is complete while busy.
    assign sample_ready = !(w_busy && r_cnt == w_thr);
    assign w_direct     = (r_cnt == w_thr);

    sample_shift_reg #(.DEPTH(N), .WIDTH(DATA_WIDTH), .LOAD_EN(1'b0)) u_shadow (
        .clk(clk), .reset_n(reset_n), .i_shift(w_acc), .i_din(sample_in),
        .i_load(1'b0), .i_load_data('0), .o_data(w_shadow)
    );

    // The copy must include a sample accepted on the same edge that enters START.
    sample_shift_reg #(.DEPTH(N), .WIDTH(DATA_WIDTH), .LOAD_EN(1'b1)) u_window (
        .clk(clk), .reset_n(reset_n), .i_shift(1'b0), .i_din('0), .i_load(w_enter_start),
        .i_load_data(w_acc ? {sample_in, w_shadow[DATA_WIDTH*N-1:DATA_WIDTH]} : w_shadow),
        .o_data(window_data)
    );
`else
    assign sample_ready = r_state inside {S_FILL, S_HOP};
    assign w_direct     = 1'b0;

    sample_shift_reg #(.DEPTH(N), .WIDTH(DATA_WIDTH), .LOAD_EN(1'b0)) u_window (
        .clk(clk), .reset_n(reset_n), .i_shift(w_acc), .i_din(sample_in),
        .i_load(1'b0), .i_load_data('0), .o_data(window_data)
    );
`endif

    // WAIT_LOW ignores a stale high ready left over from the previous frame.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FILL, S_HOP: w_next = (w_acc && r_cnt + CW'(1) == w_thr) ? S_START : r_state;
            S_START:       w_next = S_WAIT_LOW;
            S_WAIT_LOW:    w_next = engine_ready ? S_WAIT_LOW : S_WAIT_DONE;
            S_WAIT_DONE:   w_next = !engine_ready ? S_WAIT_DONE : (w_direct ? S_START : S_HOP);
            default:       w_next = S_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_FILL;
            r_cnt         <= '0;
            r_frame_count <= '0;
            r_overrun     <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_cnt         <= w_enter_start ? '0 : r_cnt + CW'(w_acc);
            r_frame_count <= r_frame_count + 16'(w_enter_start);
            r_overrun     <= r_overrun | (sample_valid & ~sample_ready);
        end
    end

    assign window_start = (r_state == S_START);
    assign window_busy  = w_busy;
    assign frame_count  = r_frame_count;
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_yin_window_loader.sv
// tb_yin_window_loader: scoreboard bench for the YIN window loader (N=12, HOP=4).
module tb_yin_window_loader;
    localparam int DW = 8, WSB = 3, MT = 4, HOP = 4, N = 12;

    logic            clk = 1'b0, reset_n = 1'b0, sample_valid = 1'b0, engine_ready = 1'b1;
    logic [DW-1:0]   sample_in = '0;
    logic            sample_ready, window_start, window_busy, overrun;
    logic [DW*N-1:0] window_data;
    logic [15:0]     frame_count;

    int              n_chk = 0, n_err = 0, n_starts = 0, ns0;
    logic [DW*N-1:0] q_win[$];
    logic [15:0]     q_frm[$];
    logic [DW*N-1:0] m_win, r_held;
    int              m_cnt, m_thr;
    logic [15:0]     m_frm;

    always #5 clk = ~clk;

    yin_window_loader #(.DATA_WIDTH(DW), .WINDOW_SIZE_BITS(WSB), .MAX_TAU(MT), .HOP_SIZE(HOP)) dut (
        .clk(clk), .reset_n(reset_n), .sample_in(sample_in), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .window_data(window_data), .window_start(window_start),
        .engine_ready(engine_ready), .window_busy(window_busy), .frame_count(frame_count),
        .overrun(overrun)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        m_win = '0;
        m_cnt = 0;
        m_thr = N;
        m_frm = '0;
        q_win.delete();
        q_frm.delete();
    endtask

    // Presents one sample, waits (bounded) for acceptance, and advances the model.
    task automatic send(input logic [DW-1:0] v);
        int t = 0;
        @(negedge clk);
        sample_in    = v;
        sample_valid = 1'b1;
        while (!sample_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!sample_ready) chk("send_timeout", sample_ready, 1);
        else begin
            @(posedge clk);
            m_win = {v, m_win[DW*N-1:DW]};
            m_cnt++;
            if (m_cnt == m_thr) begin
                m_frm++;
                q_win.push_back(m_win);
                q_frm.push_back(m_frm);
                m_cnt = 0;
                m_thr = HOP;
            end
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, sample_ready, 1);
        chk({tag, "_win"}, window_data, 0);
        chk({tag, "_start"}, window_start, 0);
        chk({tag, "_busy"}, window_busy, 0);
        chk({tag, "_frame"}, frame_count, 0);
        chk({tag, "_overrun"}, overrun, 0);
    endtask

    // Start checker: pops the expected window on each pulse, then holds it while busy.
    initial forever begin
        @(negedge clk);
        if (reset_n && window_start) begin
            n_starts++;
            r_held = window_data;
            if (q_win.size() == 0) chk("start_unexpected", window_start, 0);
            else begin
                chk("win_at_start", window_data, q_win.pop_front());
                chk("frame_at_start", frame_count, q_frm.pop_front());
            end
        end else if (reset_n && window_busy)
            chk("win_stable", window_data, r_held);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        clear_model();
        repeat (2) @(negedge clk);
        chk_reset_vals("rst");
        reset_n = 1'b1;
        for (int i = 1; i <= N; i++) send(DW'(i));
        @(negedge clk);
        sample_valid = 1'b0;
        chk("start_after_fill", window_start, 1);
        chk("fill_elem0", window_data[DW-1:0], 1);
        chk("fill_elem11", window_data[DW*N-1 -: DW], 12);
        chk("fill_frame", frame_count, 1);
        chk("fill_busy", window_busy, 1);
`ifdef YIN_LOADER_DBUF_EN
        chk("fill_ready", sample_ready, 1);
`else
        chk("fill_ready", sample_ready, 0);
`endif
        repeat (8) @(negedge clk);
        chk("stale_busy", window_busy, 1);
        chk("stale_nostart", n_starts, 1);
`ifdef YIN_LOADER_DBUF_EN
        for (int i = 13; i <= 16; i++) send(DW'(i));
        @(negedge clk);
        sample_in = 8'd17;
        chk("dbuf_full_ready", sample_ready, 0);
        repeat (2) @(negedge clk);
        chk("overrun_set", overrun, 1);
        engine_ready = 1'b0;
        repeat (5) @(negedge clk);
        chk("dbuf_wait_ready", sample_ready, 0);
        engine_ready = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        chk("dbuf_direct_start", window_start, 1);
`else
        chk("stale_ready", sample_ready, 0);
        engine_ready = 1'b0;
        repeat (3) @(negedge clk);
        sample_in    = 8'd99;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        chk("overrun_set", overrun, 1);
        repeat (16) @(negedge clk);
        chk("wait_ready", sample_ready, 0);
        engine_ready = 1'b1;
        @(negedge clk);
        chk("ready_after_done", sample_ready, 1);
        chk("idle_after_done", window_busy, 0);
        for (int i = 13; i <= 16; i++) send(DW'(i));
        @(negedge clk);
        sample_valid = 1'b0;
        chk("hop_start", window_start, 1);
`endif
        chk("hop_elem0", window_data[DW-1:0], 5);
        chk("hop_elem11", window_data[DW*N-1 -: DW], 16);
        chk("hop_frame", frame_count, 2);
        @(negedge clk);
        engine_ready = 1'b0;
        repeat (2) @(negedge clk);
        engine_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("overrun_sticky", overrun, 1);
        chk("queue_drained", q_win.size(), 0);

        reset_n = 1'b0;
        clear_model();
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 1; i <= 7; i++) send(DW'(100 + i));
        #2 reset_n = 1'b0;
        clear_model();
        #1 chk_reset_vals("midrst");
        @(negedge clk);
        sample_valid = 1'b0;
        reset_n      = 1'b1;
        ns0          = n_starts;
        for (int i = 1; i <= N - 1; i++) send(DW'(200 + i));
        @(negedge clk);
        sample_valid = 1'b0;
        chk("refill_no_early_start", window_start, 0);
        chk("refill_start_count", n_starts, ns0);
        send(8'd212);
        @(negedge clk);
        sample_valid = 1'b0;
        chk("refill_start", window_start, 1);
        chk("refill_elem0", window_data[DW-1:0], 201);
        chk("refill_frame", frame_count, 1);
        repeat (2) @(negedge clk);
        chk("final_queue_drained", q_win.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
